cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Parametrised N-way set-associative write-back, write-allocate cache controller with true-LRU replacement and block-wide memory refill/writeback. Sits between the CPU load/store port and main memory. Successor to the fixed 4-way/128-set cache data array: adds a miss-handling FSM, dirty-victim writeback, a memory handshake and hit/miss statistics.

## Interface

- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, CPU word width (power of 2, ≥8)
- NWAYS, 4, associativity (power of 2, ≥2)
- NSETS, 128, number of sets (power of 2)
- WORDS_PER_BLOCK, 16, words per line (power of 2); BLOCK_BITS = WORDS_PER_BLOCK*DATA_WIDTH
- Derived: OFFSET_W = log2(BLOCK_BITS/8), INDEX_W = log2(NSETS), TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W; defaults give offset [5:0], index [12:6], tag [31:13]
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req, cpu_we  in  1  request strobe; 1 = store
- cpu_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_busy  out  1  request in flight; cpu_req ignored while high
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  load data, valid with cpu_done
- cpu_hit  out  1  with cpu_done: 1 = no refill was needed
- mem_rd, mem_wr  out  1  block read / writeback request, held until mem_ack
- mem_addr  out  ADDR_WIDTH  block-aligned address (offset bits 0)
- mem_wdata  out  BLOCK_BITS  writeback block
- mem_rdata  in  BLOCK_BITS  refill block, valid with mem_ack
- mem_ack  in  1  completes current mem request
- hit_cnt, miss_cnt  out  32  saturating statistics counters

## Operation

- Per way/set: valid, dirty, tag, block data, age (log2(NWAYS) bits).
- States: IDLE, COMPARE, WRITEBACK, REFILL.
- IDLE: cpu_req=1 at edge → latch addr/we/wdata, cpu_busy=1, → COMPARE.
- COMPARE hit (valid & tag match, exactly one way): load returns word at offset; store writes word, sets dirty. LRU update; cpu_done=1; cpu_hit=1 unless refill occurred for this request; hit_cnt++ only if no refill; → IDLE.
- COMPARE miss: miss_cnt++; victim = lowest-index invalid way, else way with age NWAYS-1. Victim dirty → WRITEBACK, else → REFILL.
- WRITEBACK: mem_wr=1, mem_addr={victim tag,index,0}, mem_wdata=victim block. On mem_ack → REFILL.
- REFILL: mem_rd=1, mem_addr={req tag,index,0}. On mem_ack: write mem_rdata, tag, valid=1, dirty=0 into victim → COMPARE (guaranteed hit; store merges there).
- LRU on access to way w with age a: every way in set with age < a increments; w ← 0. Ages in a set remain a permutation of 0..NWAYS-1.
- Counters saturate at 0xFFFF_FFFF.
- mem_ack while neither mem_rd nor mem_wr high: ignored. cpu_req while busy: ignored.

## Timing

- Reset (async, immediate): state IDLE; all outputs 0; all valid/dirty 0; age[w]=w in every set; counters 0. Data arrays not reset.
- Request accepted at edge E0; cpu_busy high from E0.
- Hit: cpu_done/cpu_rdata/cpu_hit high for cycle E1–E2; cpu_busy falls at E1. Next request accepted no earlier than E2.
- Clean miss: mem_rd rises at E1; mem_ack sampled at edge Ea → mem_rd falls at Ea; cpu_done at Ea+1, cpu_hit=0.
- Dirty miss: mem_wr rises at E1; ack at Ew → mem_wr falls and mem_rd rises at Ew; then as clean miss.
- mem_ack may be high at the first edge after request rises (zero-wait memory legal).
- Reset mid-miss: mem_rd/mem_wr drop immediately; request discarded, no cpu_done; memory must tolerate abandoned transfer.

## Test plan

- Reset, load 0x1040, ack after 3 cycles with block word0=0xDEADBEEF → mem_rd, mem_addr=0x1040; cpu_done with rdata 0xDEADBEEF, cpu_hit=0, miss_cnt=1.
- Load 0x1040 again → cpu_done at E1, cpu_hit=1, hit_cnt=1, no mem activity.
- Store 0x12345678 to 0x1044 (hit), load 0x1044 → rdata 0x12345678, hit_cnt=3.
- Loads to 0x3040, 0x5040, 0x7040 (set 65 full), then 0x9040 → victim tag 0 dirty: mem_wr at 0x1040 with word1=0x12345678, then mem_rd at 0x9040.
- Repeat fill, touch 0x1040 before 0x9040 → victim is 0x3040 (clean), no mem_wr.
- Assert rst_n low while mem_rd=1 → mem_rd=0 same cycle, no cpu_done; after release, load 0x1040 misses, miss_cnt=1.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// CPU load/store port and block-wide memory port of the cache controller.
// Ports (as seen by cache_ctrl through the slave modport):
//   cpu_req/cpu_we/cpu_addr/cpu_wdata in;  cpu_busy/cpu_done/cpu_rdata/cpu_hit out
//   mem_rd/mem_wr/mem_addr/mem_wdata out;  mem_rdata/mem_ack in
//   hit_cnt/miss_cnt out (statistics)
// The master modport is the environment: CPU plus main memory.
interface cache_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BLOCK_BITS = 512
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_busy;
    logic                  cpu_done;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_hit;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BLOCK_BITS-1:0] mem_wdata;
    logic [BLOCK_BITS-1:0] mem_rdata;
    logic                  mem_ack;
    logic [31:0]           hit_cnt;
    logic [31:0]           miss_cnt;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_busy, cpu_done, cpu_rdata, cpu_hit,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_busy, cpu_done, cpu_rdata, cpu_hit,
        output mem_rd, mem_wr, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl.sv
// N-way set-associative write-back / write-allocate cache controller with
// true-LRU replacement, block refill and dirty-victim writeback.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cache_ctrl_if.slave: CPU request/response, memory handshake, stats
module cache_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NWAYS           = 4,
    parameter int unsigned NSETS           = 128,
    parameter int unsigned WORDS_PER_BLOCK = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    cache_ctrl_if.slave  bus
);
    localparam int unsigned BLOCK_BITS = WORDS_PER_BLOCK * DATA_WIDTH;
    localparam int unsigned OFFSET_W   = $clog2(BLOCK_BITS / 8);
    localparam int unsigned INDEX_W    = $clog2(NSETS);
    localparam int unsigned TAG_W      = ADDR_WIDTH - INDEX_W - OFFSET_W;
    localparam int unsigned BYTE_W     = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WORD_W     = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned DW_W       = $clog2(DATA_WIDTH);
    localparam int unsigned BPOS_W     = WORD_W + DW_W;
    localparam int unsigned WAY_W      = $clog2(NWAYS);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_COMPARE   = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_REFILL    = 2'd3;

    // Line storage: status bits are reset, tags and data are not.
    logic                  r_valid [NWAYS][NSETS];
    logic                  r_dirty [NWAYS][NSETS];
    logic [WAY_W-1:0]      r_age   [NWAYS][NSETS];
    logic [TAG_W-1:0]      r_tags  [NWAYS][NSETS];
    logic [BLOCK_BITS-1:0] r_data  [NWAYS][NSETS];

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [TAG_W-1:0]      r_tag;
    logic [INDEX_W-1:0]    r_index;
    logic [WORD_W-1:0]     r_word;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [WAY_W-1:0]      r_victim;
    logic                  r_refilled;

    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_hit;
    logic                  r_mem_rd;
    logic                  r_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [BLOCK_BITS-1:0] r_mem_wdata;
    logic [31:0]           r_hit_cnt;
    logic [31:0]           r_miss_cnt;

    logic                  w_hit;
    logic [WAY_W-1:0]      w_hit_way;
    logic [WAY_W-1:0]      w_hit_age;
    logic [BLOCK_BITS-1:0] w_hit_blk;
    logic [BPOS_W-1:0]     w_bitpos;
    logic [DATA_WIDTH-1:0] w_hit_word;
    logic [WAY_W-1:0]      w_victim;
    logic                  w_inv_found;
    logic                  w_victim_dirty;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_miss;
    logic                  w_wb_ack;
    logic                  w_rf_ack;

    assign bus.cpu_busy  = r_busy;
    assign bus.cpu_done  = r_done;
    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_hit   = r_hit;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.hit_cnt   = r_hit_cnt;
    assign bus.miss_cnt  = r_miss_cnt;

    // Tag lookup in the latched set.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (r_valid[w][r_index] && (r_tags[w][r_index] == r_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_hit_age  = r_age[w_hit_way][r_index];
    assign w_hit_blk  = r_data[w_hit_way][r_index];
    assign w_bitpos   = {r_word, DW_W'(0)};
    assign w_hit_word = w_hit_blk[w_bitpos +: DATA_WIDTH];

    // Victim: lowest invalid way, otherwise the least recently used one.
    always_comb begin
        w_victim    = '0;
        w_inv_found = 1'b0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (!r_valid[w][r_index] && !w_inv_found) begin
                w_victim    = WAY_W'(w);
                w_inv_found = 1'b1;
            end
        end
        if (!w_inv_found) begin
            for (int unsigned w = 0; w < NWAYS; w++) begin
                if (r_age[w][r_index] == WAY_W'(NWAYS - 1)) begin
                    w_victim = WAY_W'(w);
                end
            end
        end
    end

    assign w_victim_dirty = r_valid[w_victim][r_index] && r_dirty[w_victim][r_index];

    // Next-state and per-cycle action strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_miss      = 1'b0;
        w_wb_ack    = 1'b0;
        w_rf_ack    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_hit) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_miss      = 1'b1;
                    w_state_nxt = w_victim_dirty ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                if (bus.mem_ack) begin
                    w_wb_ack    = 1'b1;
                    w_state_nxt = S_REFILL;
                end
            end
            S_REFILL: begin
                if (bus.mem_ack) begin
                    w_rf_ack    = 1'b1;
                    w_state_nxt = S_COMPARE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, CPU/memory outputs and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag       <= '0;
            r_index     <= '0;
            r_word      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_victim    <= '0;
            r_refilled  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_hit       <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_tag      <= bus.cpu_addr[ADDR_WIDTH-1 -: TAG_W];
                r_index    <= bus.cpu_addr[OFFSET_W +: INDEX_W];
                r_word     <= bus.cpu_addr[BYTE_W +: WORD_W];
                r_we       <= bus.cpu_we;
                r_wdata    <= bus.cpu_wdata;
                r_refilled <= 1'b0;
                r_busy     <= 1'b1;
            end
            if (w_done) begin
                r_done  <= 1'b1;
                r_rdata <= w_hit_word;
                r_hit   <= !r_refilled;
                r_busy  <= 1'b0;
                if (!r_refilled && (r_hit_cnt != '1)) begin
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                end
            end
            if (w_miss) begin
                r_victim <= w_victim;
                if (r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
                if (w_victim_dirty) begin
                    r_mem_wr    <= 1'b1;
                    r_mem_addr  <= {r_tags[w_victim][r_index], r_index, {OFFSET_W{1'b0}}};
                    r_mem_wdata <= r_data[w_victim][r_index];
                end else begin
                    r_mem_rd    <= 1'b1;
                    r_mem_addr  <= {r_tag, r_index, {OFFSET_W{1'b0}}};
                end
            end
            if (w_wb_ack) begin
                r_mem_wr   <= 1'b0;
                r_mem_rd   <= 1'b1;
                r_mem_addr <= {r_tag, r_index, {OFFSET_W{1'b0}}};
            end
            if (w_rf_ack) begin
                r_mem_rd   <= 1'b0;
                r_refilled <= 1'b1;
            end
        end
    end

    // Valid/dirty/LRU state; ages start as a per-set identity permutation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned w = 0; w < NWAYS; w++) begin
                for (int unsigned s = 0; s < NSETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                    r_age[w][s]   <= WAY_W'(w);
                end
            end
        end else begin
            if (w_rf_ack) begin
                r_valid[r_victim][r_index] <= 1'b1;
                r_dirty[r_victim][r_index] <= 1'b0;
            end
            if (w_done) begin
                if (r_we) begin
                    r_dirty[w_hit_way][r_index] <= 1'b1;
                end
                for (int unsigned w = 0; w < NWAYS; w++) begin
                    if (WAY_W'(w) == w_hit_way) begin
                        r_age[w][r_index] <= '0;
                    end else if (r_age[w][r_index] < w_hit_age) begin
                        r_age[w][r_index] <= r_age[w][r_index] + WAY_W'(1);
                    end
                end
            end
        end
    end

    // Tag and data arrays: refill writes the whole line, a store hit merges one word.
    always_ff @(posedge clk) begin
        if (w_rf_ack) begin
            r_tags[r_victim][r_index] <= r_tag;
            r_data[r_victim][r_index] <= bus.mem_rdata;
        end
        if (w_done && r_we) begin
            r_data[w_hit_way][r_index][w_bitpos +: DATA_WIDTH] <= r_wdata;
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: misses, hits, store merge, dirty writeback,
// LRU victim choice and reset during an outstanding refill.
module tb_cache_ctrl;
    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;

    cache_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_BITS(512)) bus ();

    cache_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NWAYS(4), .NSETS(128), .WORDS_PER_BLOCK(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] blk(input logic [31:0] w0);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = w0 + 32'(i);
        return b;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one request; returns #1 after the accepting edge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        chk1("busy_accept", bus.cpu_busy, 1'b1);
    endtask

    task automatic expect_hit(input string tag, input logic chk_rd, input logic [31:0] rd);
        @(posedge clk);
        #1;
        chk1({tag, "_done"}, bus.cpu_done, 1'b1);
        chk1({tag, "_hit"}, bus.cpu_hit, 1'b1);
        chk1({tag, "_busy"}, bus.cpu_busy, 1'b0);
        chk1({tag, "_memrd"}, bus.mem_rd, 1'b0);
        if (chk_rd) chk32({tag, "_rdata"}, bus.cpu_rdata, rd);
    endtask

    // Ack after lat idle edges; returns #1 after the acking edge.
    task automatic mem_respond(input int unsigned lat, input logic [511:0] b);
        repeat (lat) @(posedge clk);
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = b;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
    endtask

    task automatic expect_refill_done(input string tag, input logic [31:0] rd);
        @(posedge clk);
        #1;
        chk1({tag, "_done"}, bus.cpu_done, 1'b1);
        chk1({tag, "_hit"}, bus.cpu_hit, 1'b0);
        chk32({tag, "_rdata"}, bus.cpu_rdata, rd);
    endtask

    // Load that misses into a clean victim; word 0 of the refill block is w0.
    task automatic clean_miss(input string tag, input logic [31:0] addr,
                              input logic [31:0] w0, input int unsigned lat);
        logic [31:0] baddr;
        baddr = addr & 32'hFFFF_FFC0;
        do_req(1'b0, addr, 32'h0);
        @(posedge clk);
        #1;
        chk1({tag, "_memrd"}, bus.mem_rd, 1'b1);
        chk1({tag, "_memwr"}, bus.mem_wr, 1'b0);
        chk32({tag, "_maddr"}, bus.mem_addr, baddr);
        mem_respond(lat, blk(w0));
        chk1({tag, "_memrd_drop"}, bus.mem_rd, 1'b0);
        expect_refill_done(tag, w0 + 32'((addr >> 2) & 32'hF));
    endtask

    initial begin
        n_err         = 0;
        n_chk         = 0;
        rst_n         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_busy", bus.cpu_busy, 1'b0);
        chk1("rst_done", bus.cpu_done, 1'b0);
        chk1("rst_memrd", bus.mem_rd, 1'b0);
        chk1("rst_memwr", bus.mem_wr, 1'b0);
        chk32("rst_hitcnt", bus.hit_cnt, 32'd0);
        chk32("rst_misscnt", bus.miss_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First load misses, memory answers after 3 idle cycles
        clean_miss("ld1040", 32'h0000_1040, 32'hDEAD_BEEF, 3);
        chk32("ld1040_misscnt", bus.miss_cnt, 32'd1);
        chk32("ld1040_hitcnt", bus.hit_cnt, 32'd0);

        // Same line again hits one cycle after acceptance
        do_req(1'b0, 32'h0000_1040, 32'h0);
        expect_hit("ld1040_again", 1'b1, 32'hDEAD_BEEF);
        chk32("again_hitcnt", bus.hit_cnt, 32'd1);

        // Store hit to word 1, then read it back
        do_req(1'b1, 32'h0000_1044, 32'h1234_5678);
        expect_hit("st1044", 1'b0, 32'h0);
        do_req(1'b0, 32'h0000_1044, 32'h0);
        expect_hit("ld1044", 1'b1, 32'h1234_5678);
        chk32("ld1044_hitcnt", bus.hit_cnt, 32'd3);

        // Fill the other three ways of set 65 (zero-wait, 1 and 2 cycle memory)
        clean_miss("ld3040", 32'h0000_3040, 32'h3000_0000, 0);
        clean_miss("ld5048", 32'h0000_5048, 32'h5000_0000, 1);
        clean_miss("ld707C", 32'h0000_707C, 32'h7000_0000, 2);

        // Set full: LRU victim is the dirty tag-0 line, written back first
        do_req(1'b0, 32'h0000_9040, 32'h0);
        @(posedge clk);
        #1;
        chk1("wb_memwr", bus.mem_wr, 1'b1);
        chk1("wb_memrd", bus.mem_rd, 1'b0);
        chk32("wb_maddr", bus.mem_addr, 32'h0000_1040);
        chk32("wb_word0", bus.mem_wdata[31:0], 32'hDEAD_BEEF);
        chk32("wb_word1", bus.mem_wdata[63:32], 32'h1234_5678);
        mem_respond(0, '0);
        chk1("wb_memwr_drop", bus.mem_wr, 1'b0);
        chk1("wb_then_rd", bus.mem_rd, 1'b1);
        chk32("wb_rd_maddr", bus.mem_addr, 32'h0000_9040);
        mem_respond(1, blk(32'h9000_0000));
        chk1("wb_rd_drop", bus.mem_rd, 1'b0);
        expect_refill_done("ld9040", 32'h9000_0000);
        chk32("ld9040_misscnt", bus.miss_cnt, 32'd5);
        chk32("ld9040_hitcnt", bus.hit_cnt, 32'd3);

        // Refill set 65, touch 0x1040, then 0x9040 evicts the clean 0x3040 line
        apply_reset();
        clean_miss("f1040", 32'h0000_1040, 32'hA000_0000, 0);
        clean_miss("f3040", 32'h0000_3040, 32'hB000_0000, 0);
        clean_miss("f5040", 32'h0000_5040, 32'hC000_0000, 0);
        clean_miss("f7040", 32'h0000_7040, 32'hD000_0000, 0);
        do_req(1'b0, 32'h0000_1040, 32'h0);
        expect_hit("touch1040", 1'b1, 32'hA000_0000);
        clean_miss("lru9040", 32'h0000_9040, 32'hE000_0000, 1);
        do_req(1'b0, 32'h0000_1040, 32'h0);
        expect_hit("kept1040", 1'b1, 32'hA000_0000);
        clean_miss("gone3040", 32'h0000_3040, 32'hB100_0000, 0);
        chk32("lru_misscnt", bus.miss_cnt, 32'd6);
        chk32("lru_hitcnt", bus.hit_cnt, 32'd2);

        // Reset while a refill is outstanding
        do_req(1'b0, 32'h0000_B040, 32'h0);
        @(posedge clk);
        #1;
        chk1("mid_memrd", bus.mem_rd, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_memrd", bus.mem_rd, 1'b0);
        chk1("mid_rst_busy", bus.cpu_busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk1("mid_no_done", bus.cpu_done, 1'b0);
        end
        clean_miss("post_rst1040", 32'h0000_1040, 32'h1111_0000, 2);
        chk32("post_rst_misscnt", bus.miss_cnt, 32'd1);
        chk32("post_rst_hitcnt", bus.hit_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
